// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined FP adder/subtractor.
// Flag indices, canonical quiet-NaN builder and stage-record layouts.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_SIG_W  = FP_MAN_W + 1;
  localparam int FP_XSIG_W = FP_SIG_W + 3;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INV,
    SP_INF
  } spec_e;

  // {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan_bits(
    input int unsigned ew,
    input int unsigned mw
  );
    logic [63:0] e;
    logic [63:0] q;
    e = (64'd1 << ew) - 64'd1;
    q = (e << mw) | (64'd1 << (mw - 1));
    return q;
  endfunction

  // S1 -> S2: larger operand first, smaller already aligned.
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_XSIG_W-1:0] sig_l;
    logic [FP_XSIG_W-1:0] sig_s;
    logic                 eff_sub;
    logic                 zsign;
    spec_e                spec;
    logic                 ssign;
  } s1_rec_t;

  // S2 -> S3: normalised significand with guard/round/sticky.
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W+1:0] exp;
    logic [FP_SIG_W-1:0] sig;
    logic [2:0]          grs;
    logic                zero;
    spec_e               spec;
    logic                ssign;
  } s2_rec_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: o_cnt = zeros above the top set bit of i_vec.
// Ports: i_vec (WIDTH), o_cnt (CW); all-zero input gives WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [CW-1:0]    o_cnt
);

  always_comb begin
    o_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage FP add/sub (RNE, FTZ) with valid/ready and whole-pipe stall.
// Ports: clk, rst_n, in_valid/in_ready, a, b, op_sub, out_valid/out_ready, result, flags.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 1;
  localparam int XW  = SW + 3;
  localparam int EW2 = EXP_W + 2;
  localparam int LZW = $clog2(XW + 1);

  localparam logic [EXP_W-1:0] EMAX  = '1;
  localparam logic [EXP_W-1:0] D_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [EW2-1:0] E_ONE =
    {{(EW2-1){1'b0}}, 1'b1};
  localparam logic signed [EW2-1:0] E_TOP =
    {2'b00, EMAX};
  localparam logic [W-1:0] QNAN =
    W'(qnan_bits(EXP_W, MAN_W));

  logic    w_adv;
  logic    r_v1, r_v2, r_v3;
  s1_rec_t r_s1, w_s1;
  s2_rec_t r_s2, w_s2;
  logic [W-1:0] r_res, w_res;
  logic [3:0]   r_flg, w_flg;

  // ---------------- S1: unpack / special / swap / align
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_za, w_zb;
  logic             w_na, w_nb, w_ia, w_ib;
  logic [SW-1:0]    w_ga, w_gb;
  logic [W-2:0]     w_ma, w_mb;
  logic             w_swap;
  logic             w_sl, w_ss;
  logic [EXP_W-1:0] w_el, w_es, w_d;
  logic [SW-1:0]    w_gl, w_gs;
  logic [XW-1:0]    w_xs, w_al;

  assign w_sa = a[W-1];
  assign w_ea = a[W-2 -: EXP_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_sb = b[W-1] ^ op_sub;
  assign w_eb = b[W-2 -: EXP_W];
  assign w_fb = b[MAN_W-1:0];

  // Zero exponent covers both zero and subnormal: flushed.
  assign w_za = (w_ea == '0);
  assign w_zb = (w_eb == '0);
  assign w_na = (w_ea == EMAX) && (w_fa != '0);
  assign w_nb = (w_eb == EMAX) && (w_fb != '0);
  assign w_ia = (w_ea == EMAX) && (w_fa == '0);
  assign w_ib = (w_eb == EMAX) && (w_fb == '0);

  assign w_ga = w_za ? '0 : {1'b1, w_fa};
  assign w_gb = w_zb ? '0 : {1'b1, w_fb};
  assign w_ma = w_za ? '0 : {w_ea, w_fa};
  assign w_mb = w_zb ? '0 : {w_eb, w_fb};

  assign w_swap = (w_mb > w_ma);
  assign w_sl   = w_swap ? w_sb : w_sa;
  assign w_ss   = w_swap ? w_sa : w_sb;
  assign w_el   = w_swap ? w_eb : w_ea;
  assign w_es   = w_swap ? w_ea : w_eb;
  assign w_gl   = w_swap ? w_gb : w_ga;
  assign w_gs   = w_swap ? w_ga : w_gb;
  assign w_d    = w_el - w_es;
  assign w_xs   = {w_gs, 3'b000};

  // Bits shifted past the round position fold into sticky.
  always_comb begin
    w_al = '0;
    if (w_d >= D_MAX) begin
      w_al[0] = |w_gs;
    end else begin
      w_al    = w_xs >> w_d;
      w_al[0] = w_al[0] |
        (|(w_xs & ~({XW{1'b1}} << w_d)));
    end
  end

  always_comb begin
    w_s1         = '0;
    w_s1.sign    = w_sl;
    w_s1.exp     = w_el;
    w_s1.sig_l   = {w_gl, 3'b000};
    w_s1.sig_s   = w_al;
    w_s1.eff_sub = w_sl ^ w_ss;
    // Exact zero is -0 only when both inputs are -0.
    w_s1.zsign   = w_sl & w_ss;
    w_s1.spec    = SP_NONE;
    w_s1.ssign   = 1'b0;
    if (w_na || w_nb) begin
      w_s1.spec = SP_NAN;
    end else if (w_ia && w_ib) begin
      if (w_sa != w_sb) begin
        w_s1.spec = SP_INV;
      end else begin
        w_s1.spec  = SP_INF;
        w_s1.ssign = w_sa;
      end
    end else if (w_ia) begin
      w_s1.spec  = SP_INF;
      w_s1.ssign = w_sa;
    end else if (w_ib) begin
      w_s1.spec  = SP_INF;
      w_s1.ssign = w_sb;
    end
  end

  // ---------------- S2: add/sub / normalise
  logic [XW:0]    w_sum;
  logic [LZW-1:0] w_lz;
  logic [XW-1:0]  w_norm;
  logic           w_zero;

  assign w_sum = r_s1.eff_sub ?
    ({1'b0, r_s1.sig_l} - {1'b0, r_s1.sig_s}) :
    ({1'b0, r_s1.sig_l} + {1'b0, r_s1.sig_s});
  assign w_zero = (w_sum == '0);

  fp_lzc #(
    .WIDTH (XW),
    .CW    (LZW)
  ) u_lzc (
    .i_vec (w_sum[XW-1:0]),
    .o_cnt (w_lz)
  );

  assign w_norm = w_sum[XW-1:0] << w_lz;

  always_comb begin
    w_s2       = '0;
    w_s2.sign  = w_zero ? r_s1.zsign : r_s1.sign;
    w_s2.zero  = w_zero;
    w_s2.spec  = r_s1.spec;
    w_s2.ssign = r_s1.ssign;
    if (w_sum[XW]) begin
      w_s2.sig = w_sum[XW:4];
      w_s2.grs = {w_sum[3], w_sum[2], |w_sum[1:0]};
      w_s2.exp = {2'b00, r_s1.exp} + E_ONE;
    end else begin
      w_s2.sig = w_norm[XW-1:3];
      w_s2.grs = w_norm[2:0];
      w_s2.exp = {2'b00, r_s1.exp} -
        {{(EW2-LZW){1'b0}}, w_lz};
    end
  end

  // ---------------- S3: round / pack
  logic                   w_rup;
  logic [SW:0]            w_sigr;
  logic signed [EW2-1:0]  w_er;
  logic [MAN_W-1:0]       w_frac;
  logic                   w_inx;

  assign w_rup  = r_s2.grs[2] &
    (r_s2.grs[1] | r_s2.grs[0] | r_s2.sig[0]);
  assign w_sigr = {1'b0, r_s2.sig} + {{SW{1'b0}}, w_rup};
  assign w_er   = $signed(r_s2.exp) +
    $signed({{(EW2-1){1'b0}}, w_sigr[SW]});
  assign w_frac = w_sigr[SW] ?
    w_sigr[SW-1:1] : w_sigr[MAN_W-1:0];
  assign w_inx  = |r_s2.grs;

  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (r_s2.spec == SP_NAN) begin
      w_res = QNAN;
    end else if (r_s2.spec == SP_INV) begin
      w_res          = QNAN;
      w_flg[FLG_INV] = 1'b1;
    end else if (r_s2.spec == SP_INF) begin
      w_res = {r_s2.ssign, EMAX, {MAN_W{1'b0}}};
    end else if (r_s2.zero) begin
      w_res = {r_s2.sign, {(W-1){1'b0}}};
    end else if (w_er >= E_TOP) begin
      w_res          = {r_s2.sign, EMAX, {MAN_W{1'b0}}};
      w_flg[FLG_OVF] = 1'b1;
      w_flg[FLG_INX] = 1'b1;
    end else if (w_er < E_ONE) begin
      w_res          = {r_s2.sign, {(W-1){1'b0}}};
      w_flg[FLG_UNF] = 1'b1;
      w_flg[FLG_INX] = 1'b1;
    end else begin
      w_res          = {r_s2.sign, w_er[EXP_W-1:0], w_frac};
      w_flg[FLG_INX] = w_inx;
    end
  end

  // ---------------- pipeline control
  assign w_adv = !(r_v3 && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_res <= '0;
      r_flg <= '0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_s1  <= w_s1;
      r_s2  <= w_s2;
      r_res <= w_res;
      r_flg <= w_flg;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign result    = r_res;
  assign flags     = r_flg;

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; the word width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754-style layout {sign, exp, frac}.
REQ-008 SHALL have port b  input  W  operand B, same layout.
REQ-009 SHALL have port op_sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  W  rounded sum or difference.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, valid with result.

Function
REQ-014 SHALL accept a transaction when in_valid && in_ready and present it when out_valid && out_ready.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/special-detect/swap/align, S2 add-subtract/leading-zero normalise, S3 round/pack. Latency is exactly 3 cycles with no stall.
REQ-016 SHALL drive in_ready = !(S3 valid && !out_ready); the whole pipeline advances together, and bubbles are not compressed.
REQ-017 SHALL hold result and flags stable while out_valid && !out_ready.
REQ-018 SHALL sustain throughput of 1 operation per cycle while out_ready = 1.
REQ-019 SHALL treat B as sign(B) XOR op_sub.
REQ-020 SHALL swap operands so the larger magnitude is first.
REQ-021 SHALL right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A difference of MAN_W+3 or more leaves only sticky.
REQ-022 SHALL round to nearest, ties to even; inexact = G|R|S before rounding.
REQ-023 SHALL renormalise when rounding carries out, incrementing the exponent.
REQ-024 SHALL flush subnormal inputs to signed zero (FTZ).
REQ-025 SHALL flush results whose exponent falls below 1 to signed zero and set underflow and inexact.
REQ-026 SHALL return +infinity or -infinity on exponent overflow (exp >= all-ones), setting overflow and inexact.
REQ-027 SHALL return exact-zero results as +0, except (-0)+(-0) = -0.
REQ-028 SHALL return canonical quiet NaN {0, all-ones, 1 followed by zeros} for any NaN operand, without setting invalid.
REQ-029 SHALL return canonical NaN with invalid set for inf-inf of opposite effective signs.
REQ-030 SHALL return the infinity operand unchanged for inf op finite, with no flags.
REQ-031 SHALL derive result flags only from the transaction they belong to; no sticky accumulation.

Reset
REQ-032 SHALL clear all stage-valid bits on rst_n low, immediately and regardless of clk.
REQ-033 SHALL drive out_valid = 0, result = 0, flags = 0 and in_ready = 1 during reset.
REQ-034 SHALL discard in-flight operations on reset mid-operation; no output for them appears after release.
REQ-035 SHALL accept a new operation on the first rising edge after rst_n rises.

Structure
REQ-036 SHALL place the flag bit indices, the canonical-NaN constant builder and the stage-record typedefs (sign, exp, extended significand, GRS, special-case code) in shared package fp_pkg.
REQ-037 SHALL use exactly one sub-module, fp_lzc (parametrised leading-zero counter), instanced in S2.
REQ-038 SHALL use only parameter-derived widths, with no hard-coded 32-bit constants.

Verification
REQ-039 SHALL cover: a=0x3F980000, b=0x3F900000, op_sub=0 -> result 0x40140000, flags 0, out_valid 3 cycles after accept.
REQ-040 SHALL cover: a=0x3F980000, b=0x3F100000, op_sub=1 -> result 0x3F200000, flags 0.
REQ-041 SHALL cover: a=b=0x3F980000, op_sub=1 -> result 0x00000000; then a=0x7F800000, b=0x7F800000, op_sub=1 -> result 0x7FC00000, invalid=1.
REQ-042 SHALL cover: a=b=0x7F7FFFFF, op_sub=0 -> result 0x7F800000, overflow=1, inexact=1; a=0x3F800000, b=0x33800000 (2^-24), add -> 0x3F800000 (tie to even), inexact=1.
REQ-043 SHALL cover: 5 back-to-back ops with out_ready low for cycles 4-6 -> in_ready drops, results held stable, all 5 delivered in order, none lost or duplicated.
REQ-044 SHALL cover: rst_n pulsed low while 2 ops are in flight -> out_valid 0 at once, neither op emitted, next op returns its result 3 cycles after accept.
